// File: rtl/itch_pkg.sv
// Shared ITCH definitions: Cancel Order ('X') constants, the decoder's
// 512-bit payload field offsets, and the encoder FSM state type.
package itch_pkg;

  // Cancel Order message identity and size (1 type + 8 order ref + 4 shares)
  localparam logic [7:0]  MSG_TYPE_CANCEL = 8'h58;
  localparam int unsigned CANCEL_MSG_LEN  = 13;
  localparam int unsigned CANCEL_MSG_BITS = CANCEL_MSG_LEN * 8;

  // Field positions inside the 512-bit payload word, bytes packed MSB-first
  localparam int unsigned TYPE_MSB   = 511;
  localparam int unsigned REF_MSB    = 503;
  localparam int unsigned REF_LSB    = 440;
  localparam int unsigned SHARES_MSB = 439;
  localparam int unsigned SHARES_LSB = 408;

  // Encoder FSM states
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } enc_state_t;

  // Big-endian field packing: type byte first, then order ref, then shares
  function automatic logic [CANCEL_MSG_BITS-1:0] pack_cancel(
    input logic [7:0]  msg_type,
    input logic [63:0] order_ref,
    input logic [31:0] shares
  );
    return {msg_type, order_ref, shares};
  endfunction

endpackage

// File: rtl/msg_byte_serializer.sv
// Generic N-byte shift-out stage with valid/ready, sop/eop flags and a
// load port that may coincide with the last-byte handshake for
// bubble-free back-to-back messages. The caller must only assert load
// when the stage is empty or the last byte is being accepted.
module msg_byte_serializer #(
  parameter int unsigned N_BYTES = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [N_BYTES*8-1:0] load_data,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic                 last_hs
);

  localparam int unsigned     IDX_W    = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  logic [N_BYTES*8-1:0] shreg;
  logic [IDX_W-1:0]     byte_idx;
  logic                 valid_q;
  logic                 hs;

  assign hs      = valid_q && out_ready;
  assign last_hs = hs && (byte_idx == LAST_IDX);

  // Holding shift register, byte index and valid flag; nothing moves
  // while the current byte is stalled by the downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      byte_idx <= '0;
      valid_q  <= 1'b0;
    end else if (load) begin
      shreg    <= load_data;
      byte_idx <= '0;
      valid_q  <= 1'b1;
    end else if (hs) begin
      shreg <= {shreg[N_BYTES*8-9:0], 8'h00};
      if (byte_idx == LAST_IDX) begin
        byte_idx <= '0;
        valid_q  <= 1'b0;
      end else begin
        byte_idx <= byte_idx + 1'b1;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = shreg[N_BYTES*8-1 -: 8];
  assign out_sop   = valid_q && (byte_idx == '0);
  assign out_eop   = valid_q && (byte_idx == LAST_IDX);

endmodule

// File: rtl/cancel_order_encoder.sv
// ITCH Cancel Order ('X') encoder: latches field-level requests into a
// 13-byte big-endian message and streams it out one byte per cycle.
module cancel_order_encoder
  import itch_pkg::*;
#(
  parameter logic [7:0]  MSG_TYPE = MSG_TYPE_CANCEL,
  parameter int unsigned MSG_LEN  = CANCEL_MSG_LEN,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [63:0]      req_order_ref,
  input  logic [31:0]      req_shares,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic             busy,
  output logic [CNT_W-1:0] msg_count
);

  enc_state_t             state, next_state;
  logic                   accept;
  logic                   last_hs;
  logic [MSG_LEN*8-1:0]   msg_word;

  assign msg_word = pack_cancel(MSG_TYPE, req_order_ref, req_shares);

  // Ready when idle, or combinationally from out_ready while the final byte
  // is being taken so the next message starts without a bubble.
  assign req_ready = (state == IDLE) || ((state == SEND) && last_hs);
  assign accept    = req_valid && req_ready;

  msg_byte_serializer #(
    .N_BYTES (MSG_LEN)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .load_data (msg_word),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .last_hs   (last_hs)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state: start on accept, leave SEND only when the last byte goes
  // out with no new request waiting
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SEND;
      SEND:    if (last_hs && !accept) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state == SEND);

  // Completed-message counter, wraps freely
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       msg_count <= '0;
    else if (last_hs) msg_count <= msg_count + 1'b1;
  end

endmodule

// File: tb/tb_cancel_order_encoder.sv
// Self-checking bench for cancel_order_encoder: a byte-queue reference
// model built from the message layout, directed and randomized traffic.
module tb_cancel_order_encoder;
  import itch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [63:0] req_order_ref;
  logic [31:0] req_shares;
  logic        out_ready;

  logic        req_ready, out_valid, out_sop, out_eop, busy;
  logic [7:0]  out_data;
  logic [15:0] msg_count;

  logic        w2_req_ready, w2_out_valid, w2_out_sop, w2_out_eop, w2_busy;
  logic [7:0]  w2_out_data;
  logic [1:0]  w2_msg_count;

  always #5 clk = ~clk;

  cancel_order_encoder dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_order_ref(req_order_ref), .req_shares(req_shares),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .busy(busy), .msg_count(msg_count)
  );

  cancel_order_encoder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(w2_req_ready),
    .req_order_ref(req_order_ref), .req_shares(req_shares),
    .out_valid(w2_out_valid), .out_ready(out_ready), .out_data(w2_out_data),
    .out_sop(w2_out_sop), .out_eop(w2_out_eop), .busy(w2_busy),
    .msg_count(w2_msg_count)
  );

  typedef struct {
    logic [7:0] d;
    bit         sop;
    bit         eop;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] pref_q[$];
  logic [31:0] psh_q[$];
  logic [7:0]  rx_q[$];

  int          tests = 0;
  int          fails = 0;
  int unsigned model_cnt = 0;
  int unsigned pat_i = 0;
  int unsigned eop_seen = 0;
  int          mode = 0;
  bit          prev_stall = 0;
  logic [7:0]  prev_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Byte k of a cancel message straight from the field layout
  function automatic logic [7:0] msg_byte(int k, logic [63:0] r, logic [31:0] s);
    if (k == 0) return 8'h58;
    if (k <= 8) return 8'(r >> (8 * (8 - k)));
    return 8'(s >> (8 * (12 - k)));
  endfunction

  task automatic push_msg(input logic [63:0] r, input logic [31:0] s);
    for (int k = 0; k < 13; k++) begin
      exp_t e;
      e.d = msg_byte(k, r, s);
      e.sop = (k == 0);
      e.eop = (k == 12);
      exp_q.push_back(e);
    end
  endtask

  task automatic request(input logic [63:0] r, input logic [31:0] s);
    pref_q.push_back(r);
    psh_q.push_back(s);
  endtask

  // One clock: drive at edge+1, check at edge+2, then advance the model
  task automatic cycle();
    bit rdy, ev, er, hs;
    case (mode)
      0:       rdy = 1'b1;
      1:       rdy = (pat_i % 4 == 0) || (pat_i % 4 == 3);
      default: rdy = 1'($urandom_range(0, 1));
    endcase
    out_ready = rdy;
    if (pref_q.size() != 0) begin
      req_valid = 1'b1;
      req_order_ref = pref_q[0];
      req_shares = psh_q[0];
    end else begin
      req_valid = 1'b0;
      req_order_ref = {$urandom, $urandom};
      req_shares = $urandom;
    end
    #1;
    ev = (exp_q.size() != 0);
    er = !ev || (exp_q.size() == 1 && rdy);
    chk("out_valid", out_valid, ev);
    chk("busy", busy, ev);
    chk("req_ready", req_ready, er);
    if (ev) begin
      chk("out_data", out_data, exp_q[0].d);
      chk("out_sop", out_sop, exp_q[0].sop);
      chk("out_eop", out_eop, exp_q[0].eop);
    end else begin
      chk("idle_sop", out_sop, 1'b0);
      chk("idle_eop", out_eop, 1'b0);
    end
    if (prev_stall) chk("stall_hold", out_data, prev_data);
    chk("msg_count", msg_count, 16'(model_cnt));
    chk("msg_count_w2", w2_msg_count, 2'(model_cnt % 4));
    hs = ev && rdy;
    prev_stall = ev && !rdy;
    prev_data = out_data;
    if (hs) begin
      rx_q.push_back(out_data);
      if (exp_q[0].eop) begin
        model_cnt++;
        eop_seen++;
      end
      void'(exp_q.pop_front());
    end
    if (req_valid && er) push_msg(pref_q.pop_front(), psh_q.pop_front());
    @(posedge clk);
    #1;
    pat_i++;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || pref_q.size() != 0) && n < limit) begin
      cycle();
      n++;
    end
    tests++;
    assert (n < limit)
    else begin
      fails++;
      $error("FAIL drain_timeout observed=%0d cycles expected<%0d", n, limit);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    pref_q.delete();
    model_cnt = 0;
    prev_stall = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_msg_count", msg_count, 16'h0);
    chk("rst_req_ready", req_ready, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin : main
    logic [7:0]   spec_bytes [13];
    logic [1:0]   wrap_exp [5];
    logic [511:0] word;
    int           n;
    int unsigned  c0;

    spec_bytes = '{8'h58, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB,
                   8'hCD, 8'hEF, 8'h00, 8'h00, 8'h03, 8'hE8};
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    req_order_ref = '0;
    req_shares = '0;
    do_reset();

    // Single message, ready held high
    mode = 0;
    rx_q.delete();
    request(64'h0123_4567_89AB_CDEF, 32'h0000_03E8);
    drain(40);
    cycle();
    chk("single_len", rx_q.size(), 13);
    for (int i = 0; i < 13; i++) chk("single_byte", rx_q[i], spec_bytes[i]);
    chk("single_count", msg_count, 16'd1);

    // Backpressure 1,0,0,1 pattern
    mode = 1;
    pat_i = 0;
    eop_seen = 0;
    rx_q.delete();
    request(64'h0123_4567_89AB_CDEF, 32'h0000_03E8);
    drain(80);
    chk("bp_len", rx_q.size(), 13);
    for (int i = 0; i < 13; i++) chk("bp_byte", rx_q[i], spec_bytes[i]);
    chk("bp_eop_once", eop_seen, 1);

    // Back-to-back requests
    mode = 0;
    c0 = model_cnt;
    request(64'd1, 32'd10);
    request(64'd2, 32'd20);
    drain(60);
    cycle();
    chk("b2b_count", msg_count, 16'(c0 + 2));

    // Loopback through the 512-bit payload layout
    rx_q.delete();
    request(64'hFFFF_FFFF_FFFF_FFFF, 32'h0);
    drain(40);
    word = '0;
    for (int i = 0; i < 13 && i < rx_q.size(); i++) word[511 - 8 * i -: 8] = rx_q[i];
    chk("lb_type", word[TYPE_MSB -: 8], 8'h58);
    chk("lb_ref", word[REF_MSB:REF_LSB], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("lb_shares", word[SHARES_MSB:SHARES_LSB], 32'h0);
    chk("lb_tail", word[407:0] == '0, 1'b1);

    // Reset in the middle of a message
    rx_q.delete();
    request(64'hDEAD_BEEF_0000_1111, 32'h1234_5678);
    n = 0;
    while (rx_q.size() < 6 && n < 40) begin
      cycle();
      n++;
    end
    chk("mid_reached", rx_q.size(), 6);
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_sop", out_sop, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_count", msg_count, 16'h0);
    exp_q.delete();
    pref_q.delete();
    psh_q.delete();
    model_cnt = 0;
    prev_stall = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("mid_rel_ready", req_ready, 1'b1);
    chk("mid_rel_count", msg_count, 16'h0);
    @(posedge clk);
    #1;
    rx_q.delete();
    request(64'h0123_4567_89AB_CDEF, 32'h0000_03E8);
    drain(40);
    chk("fresh_len", rx_q.size(), 13);
    for (int i = 0; i < 13; i++) chk("fresh_byte", rx_q[i], spec_bytes[i]);

    // Counter wrap on the 2-bit instance
    do_reset();
    for (int i = 0; i < 5; i++) begin
      request({$urandom, $urandom}, $urandom);
      drain(40);
      chk("wrap_count", w2_msg_count, wrap_exp[i]);
    end

    // Randomized traffic with random backpressure and idle gaps
    mode = 2;
    for (int i = 0; i < 20; i++) begin
      request({$urandom, $urandom}, $urandom);
      if ($urandom_range(0, 3) == 0) request('0, '0);
      if ($urandom_range(0, 2) == 0) drain(200);
    end
    drain(1500);
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cancel_order_encoder.md
Name: cancel_order_encoder

Overview:
Builds ITCH Cancel Order ('X') messages from field-level requests and streams them out one byte per cycle with valid/ready backpressure. It is the transmit counterpart of the payload-side cancel decoder. It feeds the test/loopback path and the order-entry replay path that produces the byte stream later packed into 512-bit payloads. Byte order matches the decoder's payload layout exactly once the bytes are packed MSB-first.

Parameters:
MSG_TYPE, 8'h58 ('X'), message type byte emitted first.
MSG_LEN, 13, bytes per message (1 type + 8 order ref + 4 shares).
CNT_W, 16, width of the sent-message counter.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  cancel request present.
req_ready  output  1  encoder can accept a request this cycle.
req_order_ref  input  64  order reference number.
req_shares  input  32  canceled share count.
out_valid  output  1  out_data holds a valid byte.
out_ready  input  1  downstream accepts the byte.
out_data  output  8  message byte.
out_sop  output  1  first byte of message (the type byte).
out_eop  output  1  last byte of message (shares LSB).
busy  output  1  a message is in flight.
msg_count  output  CNT_W  number of fully transmitted messages, wraps.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. out_valid=0, out_data=0, out_sop=0, out_eop=0, busy=0, msg_count=0, byte index=0, holding register cleared. Any partial message is abandoned; no resume after reset.
- Request handshake: a request is accepted when req_valid && req_ready at a rising edge. The accepted message register latches {MSG_TYPE, req_order_ref, req_shares}, 104 bits.
- req_ready = (state==IDLE) || (state==SEND && out_valid && out_ready && byte_idx==MSG_LEN-1). This is a combinational path from out_ready to req_ready. It allows back-to-back messages with no bubble.
- FSM states:
  - IDLE to SEND on accept.
  - SEND to SEND on the last-byte handshake with a simultaneous accept; byte_idx reloads to 0 and the new message is latched.
  - SEND to IDLE on the last-byte handshake with no accept.
- Latency: request accepted at edge N, so out_valid=1 with byte 0 (MSG_TYPE) and out_sop=1 from cycle N+1. With out_ready held high, byte k appears at cycle N+1+k and eop at N+13.
- Byte order is big-endian:
  - byte 0 = type.
  - bytes 1..8 = order_ref[63:56] .. [7:0].
  - bytes 9..12 = shares[31:24] .. [7:0].
- Backpressure: while out_valid && !out_ready, out_data, out_sop, out_eop and byte_idx hold stable. The encoder never drops or repeats a byte.
- out_valid stays high for the whole message once started. There are no gaps inserted by the encoder.
- out_sop=1 only when byte_idx==0. out_eop=1 only when byte_idx==MSG_LEN-1. Both are 0 when out_valid=0.
- busy = (state==SEND).
- msg_count increments by 1 on each last-byte handshake. It wraps modulo 2^CNT_W with no saturation.
- Field values are taken verbatim: shares=0 and order_ref=0 are legal and encoded unchanged. No validation is done.
- req_* fields are sampled only at accept. Changes at other times have no effect.

Decomposition:
- Shared package itch_pkg holds:
  - MSG_TYPE_CANCEL = 8'h58 and CANCEL_MSG_LEN = 13.
  - Payload field offsets for the decoder: TYPE_MSB=511, REF_MSB=503, REF_LSB=440, SHARES_MSB=439, SHARES_LSB=408.
  - An enum for FSM states {IDLE, SEND}.
- One natural sub-module: msg_byte_serializer. It is a generic N-byte shift-out with valid/ready, sop/eop and a reload-on-last port. The encoder is then field packing, counter and req_ready logic around it.

Test Plan:
- Single message, out_ready=1: ref=64'h0123_4567_89AB_CDEF, shares=32'h0000_03E8, accepted at edge N. Required: bytes 58 01 23 45 67 89 AB CD EF 00 00 03 E8 on cycles N+1..N+13, sop on the first byte, eop on the last, msg_count=1, req_ready=1 at N+14.
- Backpressure: same request, out_ready toggled 1,0,0,1 repeating. Required: identical 13-byte sequence; out_data stable during every stall; no duplicates; eop only once.
- Back-to-back: two requests held valid, ref=1/shares=10 then ref=2/shares=20, out_ready=1. Required: 26 consecutive valid cycles with no bubble, second sop directly after first eop, msg_count=2.
- Loopback: pack 13 bytes MSB-first into a 512-bit word from bit 511 down, zero-fill the rest, and feed the cancel decoder. Required: decoded flag set, order_ref and shares equal the inputs (ref=64'hFFFF_FFFF_FFFF_FFFF, shares=0).
- Reset mid-message: assert rst_n=0 after byte 5. Required: out_valid=0 immediately (async); after release req_ready=1, msg_count=0; the next request emits a full fresh message starting with 58.
- Counter wrap with CNT_W=2: send 5 messages. Required: msg_count sequence 1,2,3,0,1.
